// File: rtl/codec_init_sequencer_pkg.sv
// Shared definitions for the codec init sequencer: I2C mode constants, codec address,
// codec register map, FSM state encoding and the table-word packing helper.
package codec_init_sequencer_pkg;

    localparam logic       MODE_READ      = 1'b0;
    localparam logic       MODE_WRITE     = 1'b1;
    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;

    localparam logic [6:0] REG_LLIN    = 7'h00;
    localparam logic [6:0] REG_RLIN    = 7'h01;
    localparam logic [6:0] REG_ANALOG  = 7'h04;
    localparam logic [6:0] REG_DIGITAL = 7'h05;
    localparam logic [6:0] REG_POWER   = 7'h06;
    localparam logic [6:0] REG_FORMAT  = 7'h07;
    localparam logic [6:0] REG_SAMPLE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE  = 7'h09;
    localparam logic [6:0] REG_RESET   = 7'h0F;

    localparam int CNT_W   = 17;
    localparam int IDX_W   = 4;
    localparam int RETRY_W = 3;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_LOAD,
        ST_REQ,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Codec registers carry 9 data bits, so the address shares the first byte with data[8].
    function automatic logic [15:0] reg_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_init_sequencer_if.sv
// Handshake bundle between the init sequencer (master) and the I2C controller (slave).
interface codec_init_sequencer_if;

    logic       enable;
    logic       mode;
    logic [6:0] periph_addr;
    logic [7:0] data_byte;
    logic       byte_last;
    logic       busy;
    logic       byte_req;
    logic       txn_done;
    logic       ack_ok;

    modport master (
        output enable, mode, periph_addr, data_byte, byte_last,
        input  busy, byte_req, txn_done, ack_ok
    );

    modport slave (
        input  enable, mode, periph_addr, data_byte, byte_last,
        output busy, byte_req, txn_done, ack_ok
    );

endinterface

// File: rtl/codec_init_sequencer_rom.sv
// Codec register table: reset, power-up, input levels, path setup, format, rate, activate.
module codec_reg_rom
    import codec_init_sequencer_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        case (index)
            4'd0:    word = reg_word(REG_RESET,   9'h000);
            4'd1:    word = reg_word(REG_POWER,   9'h010);
            4'd2:    word = reg_word(REG_LLIN,    9'h017);
            4'd3:    word = reg_word(REG_RLIN,    9'h017);
            4'd4:    word = reg_word(REG_ANALOG,  9'h012);
            4'd5:    word = reg_word(REG_DIGITAL, 9'h000);
            4'd6:    word = reg_word(REG_FORMAT,  9'h00A);
            4'd7:    word = reg_word(REG_SAMPLE,  9'h000);
            // Outputs are powered last so the DAC path comes up without a pop.
            4'd8:    word = reg_word(REG_POWER,   9'h000);
            4'd9:    word = reg_word(REG_ACTIVE,  9'h001);
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec register table after reset, issuing one 2-byte I2C write per entry with
// retry on NACK/timeout, and reports init_done / init_error to the synth top level.
module codec_init_sequencer
    import codec_init_sequencer_pkg::*;
#(
    parameter int         NUM_REGS     = 10,
    parameter logic [6:0] PERIPH_ADDR  = CODEC_I2C_ADDR,
    parameter int         POWERUP_WAIT = 50000,
    parameter int         GAP_CYCLES   = 256,
    parameter int         TIMEOUT      = 100000,
    parameter int         MAX_RETRIES  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    codec_init_sequencer_if.master ctl,
    output logic [IDX_W-1:0]       reg_index,
    output logic                   init_done,
    output logic                   init_error
);

    localparam logic [CNT_W-1:0]   POWERUP_END = CNT_W'(POWERUP_WAIT);
    localparam logic [CNT_W-1:0]   GAP_END     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WDOG_END    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [RETRY_W-1:0] retries, retries_n, retry_inc;
    logic [15:0]        word, rom_word;
    logic               wdog_expired;
    logic               fail;

    codec_reg_rom u_rom (
        .index (idx),
        .word  (rom_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_POWERUP;
            cnt     <= '0;
            idx     <= '0;
            retries <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            retries <= retries_n;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD) word <= rom_word;
    end

    // One counter serves as powerup delay, inter-transaction gap and handshake watchdog.
    assign wdog_expired = (cnt == WDOG_END);
    assign retry_inc    = retries + RETRY_W'(1);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        retries_n = retries;
        fail      = 1'b0;
        unique case (state)
            ST_POWERUP: begin
                if (cnt == POWERUP_END) begin
                    state_n   = ST_LOAD;
                    idx_n     = '0;
                    retries_n = '0;
                end
            end
            ST_LOAD: state_n = ST_REQ;
            // A txn_done before WAIT_DONE means the address byte was NACKed.
            ST_REQ: begin
                if (ctl.txn_done || wdog_expired) fail = 1'b1;
                else if (ctl.busy)                state_n = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (ctl.txn_done || wdog_expired) fail = 1'b1;
                else if (ctl.byte_req)            state_n = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                if (ctl.txn_done || wdog_expired) fail = 1'b1;
                else if (ctl.byte_req)            state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (ctl.txn_done) begin
                    if (ctl.ack_ok) begin
                        idx_n     = idx + IDX_W'(1);
                        retries_n = '0;
                        state_n   = (idx == LAST_IDX) ? ST_DONE : ST_GAP;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (wdog_expired) begin
                    fail = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_END) state_n = ST_LOAD;
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_n   = ST_LOAD;
                    idx_n     = '0;
                    retries_n = '0;
                end
            end
            default: state_n = ST_POWERUP;
        endcase

        if (fail) begin
            retries_n = retry_inc;
            state_n   = (retry_inc > RETRY_LIMIT) ? ST_ERROR : ST_GAP;
        end

        if (state_n != state)  cnt_n = '0;
        else if (cnt == CNT_MAX) cnt_n = cnt;
        else                   cnt_n = cnt + CNT_W'(1);
    end

    assign ctl.enable      = (state == ST_REQ);
    assign ctl.mode        = MODE_WRITE;
    assign ctl.periph_addr = PERIPH_ADDR;
    assign ctl.byte_last   = (state == ST_SEND_LO);
    assign ctl.data_byte   = (state == ST_REQ || state == ST_SEND_HI) ? word[15:8] :
                             (state == ST_SEND_LO)                    ? word[7:0]  : 8'h00;

    assign reg_index  = idx;
    assign init_done  = (state == ST_DONE);
    assign init_error = (state == ST_ERROR);

endmodule
